// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified-memory arbiter.
//   arb_state_t : arbiter state (free round-robin / locked burst)
//   REQ_FETCH / REQ_EXEC : fixed requester slots
//   MAX_REQ / TAG_W      : largest supported requester count and its index width
//   STAT_W               : width of the optional statistics counters
//   tag_onehot()         : requester index to one-hot vector
//   sat_inc()            : saturating increment for statistics counters
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam int REQ_FETCH = 0;
    localparam int REQ_EXEC  = 1;
    localparam int MAX_REQ   = 4;
    localparam int TAG_W     = $clog2(MAX_REQ);
    localparam int STAT_W    = 16;

    function automatic logic [MAX_REQ-1:0] tag_onehot(input logic [TAG_W-1:0] tag);
        logic [MAX_REQ-1:0] oh;
        oh      = '0;
        oh[tag] = 1'b1;
        return oh;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: returns the first requesting index at or
// after ptr_i, scanning upward and wrapping at NUM_REQ.
//   req_i   : request vector, padded to MAX_REQ (only NUM_REQ bits examined)
//   ptr_i   : round-robin start index (< NUM_REQ)
//   valid_o : at least one request present
//   idx_o   : winning index
// -----------------------------------------------------------------------------
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [MAX_REQ-1:0] req_i,
    input  logic [TAG_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [TAG_W-1:0]   idx_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        // Scan from the farthest offset down to zero so the nearest requester
        // at or after the pointer is the last (and therefore final) writer.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int unsigned      sum;
            logic [TAG_W-1:0] cand;
            sum = int'(ptr_i) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = TAG_W'(sum);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single-port unified memory between NUM_REQ requesters (fetch,
// execution load/store, future DMA/debug). Round-robin arbitration, a burst
// lock that keeps the port with one requester, and fixed-latency read return
// tagged per requester. The memory side is muxed combinationally, so a beat is
// issued in its grant cycle.
//
// Optional build macro: MEM_ARB_STATS_EN adds saturating per-requester grant
// counters and a conflict counter; without it the stat ports read as zero.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   req/lock/we        : per-requester request, burst hold, write enable
//   addr/wdata         : per-requester address and write data
//   gnt                : one-hot grant (beat = req[i] & gnt[i])
//   rvalid             : read data valid for requester i
//   rdata              : mem_rdata broadcast to all requesters
//   mem_we/addr/wdata  : memory command (zero when nothing is granted)
//   mem_rdata          : memory read data
//   busy               : grant active, burst locked, or reads in flight
//   stat_gnt_cnt       : per-requester grant count (saturating)
//   stat_conflict_cnt  : cycles with more than one request (saturating)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ-1:0]                   lock,
    input  logic [NUM_REQ-1:0]                   we,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]                   gnt,
    output logic [NUM_REQ-1:0]                   rvalid,
    output logic [DATA_WIDTH-1:0]                rdata,
    output logic                                 mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    input  logic [DATA_WIDTH-1:0]                mem_rdata,
    output logic                                 busy,
    output logic [NUM_REQ-1:0][STAT_W-1:0]       stat_gnt_cnt,
    output logic [STAT_W-1:0]                    stat_conflict_cnt
);

    arb_state_t       state_q, state_d;
    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0] owner_q, owner_d;

    logic             pick_valid;
    logic [TAG_W-1:0] pick_idx;
    logic             grant_valid;
    logic [TAG_W-1:0] grant_idx;
    logic             read_beat;
    logic [MAX_REQ-1:0] gnt_full;
    logic [MAX_REQ-1:0] rvalid_full;

    // Requester inputs padded to MAX_REQ so a TAG_W-bit index always fits.
    logic [MAX_REQ-1:0]                 req_x, lock_x, we_x;
    logic [MAX_REQ-1:0][ADDR_WIDTH-1:0] addr_x;
    logic [MAX_REQ-1:0][DATA_WIDTH-1:0] wdata_x;

    // Read-return tag pipeline: slot 0 is loaded in the issue cycle, the last
    // slot drives rvalid READ_LATENCY cycles later.
    logic [READ_LATENCY-1:0]            pv_q;
    logic [READ_LATENCY-1:0][TAG_W-1:0] ptag_q;

    function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        req_x   = '0;
        lock_x  = '0;
        we_x    = '0;
        addr_x  = '0;
        wdata_x = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_x[k]   = req[k];
            lock_x[k]  = lock[k];
            we_x[k]    = we[k];
            addr_x[k]  = addr[k];
            wdata_x[k] = wdata[k];
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i   (req_x),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Next-state / grant decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        grant_valid = 1'b0;
        grant_idx   = pick_idx;

        unique case (state_q)
            ST_FREE: begin
                if (pick_valid) begin
                    grant_valid = 1'b1;
                    rr_ptr_d    = wrap_inc(pick_idx);
                    if (lock_x[pick_idx]) begin
                        state_d = ST_LOCKED;
                        owner_d = pick_idx;
                    end
                end
            end
            ST_LOCKED: begin
                // Other requesters are ignored; the owner keeps the port for
                // as long as it keeps both req and lock high.
                grant_idx   = owner_q;
                grant_valid = req_x[owner_q];
                if (!(req_x[owner_q] && lock_x[owner_q])) begin
                    state_d  = ST_FREE;
                    rr_ptr_d = wrap_inc(owner_q);
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    assign gnt_full  = grant_valid ? tag_onehot(grant_idx) : '0;
    assign gnt       = gnt_full[NUM_REQ-1:0];
    assign read_beat = grant_valid & ~we_x[grant_idx];

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_valid) begin
            mem_we    = we_x[grant_idx] & req_x[grant_idx];
            mem_addr  = addr_x[grant_idx];
            mem_wdata = wdata_x[grant_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FREE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            pv_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of its neighbours (the pipeline shifts correctly).
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            pv_q[0]  <= read_beat;
            for (int k = 1; k < READ_LATENCY; k++) begin
                pv_q[k] <= pv_q[k-1];
            end
        end
    end

    // NOTE: the tag payload carries no reset; it is only ever observed through
    // its valid bit, which is reset above.
    always_ff @(posedge clk) begin
        ptag_q[0] <= grant_idx;
        for (int k = 1; k < READ_LATENCY; k++) begin
            ptag_q[k] <= ptag_q[k-1];
        end
    end

    assign rvalid_full = pv_q[READ_LATENCY-1] ? tag_onehot(ptag_q[READ_LATENCY-1]) : '0;
    assign rvalid      = rvalid_full[NUM_REQ-1:0];
    assign rdata       = mem_rdata;
    assign busy        = (|gnt) | (state_q == ST_LOCKED) | (|pv_q);

`ifdef MEM_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] gnt_cnt_q;
    logic [STAT_W-1:0]              conflict_cnt_q;
    logic                           conflict;

    // More than one bit set: clearing the lowest set bit leaves something.
    assign conflict = (req & (req - 1'b1)) != '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt_q      <= '0;
            conflict_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (gnt[k]) begin
                    gnt_cnt_q[k] <= sat_inc(gnt_cnt_q[k]);
                end
            end
            if (conflict) begin
                conflict_cnt_q <= sat_inc(conflict_cnt_q);
            end
        end
    end

    assign stat_gnt_cnt      = gnt_cnt_q;
    assign stat_conflict_cnt = conflict_cnt_q;
`else
    assign stat_gnt_cnt      = '0;
    assign stat_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Three arbiter instances (READ_LATENCY 1, 2, 3) share one directed stimulus
// stream, each with its own memory model. Expected reads are queued at issue
// and retired once every latency has returned.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int NI = 3;

    logic clk;
    logic rst_n;
    logic [1:0]       req, lock, we;
    logic [1:0][15:0] addr;
    logic [1:0][7:0]  wdata;

    logic [1:0]        gnt_a        [NI];
    logic [1:0]        rvalid_a     [NI];
    logic [7:0]        rdata_a      [NI];
    logic              mem_we_a     [NI];
    logic [15:0]       mem_addr_a   [NI];
    logic [7:0]        mem_wdata_a  [NI];
    logic              busy_a       [NI];
    logic [1:0][15:0]  stat_gnt_a   [NI];
    logic [15:0]       stat_conf_a  [NI];

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int LAT = k + 1;
        logic [7:0] mem   [0:65535];
        logic [7:0] rpipe [LAT];

        mem_arbiter #(
            .NUM_REQ      (2),
            .ADDR_WIDTH   (16),
            .DATA_WIDTH   (8),
            .READ_LATENCY (LAT)
        ) u_dut (
            .clk               (clk),
            .rst_n             (rst_n),
            .req               (req),
            .lock              (lock),
            .we                (we),
            .addr              (addr),
            .wdata             (wdata),
            .gnt               (gnt_a[k]),
            .rvalid            (rvalid_a[k]),
            .rdata             (rdata_a[k]),
            .mem_we            (mem_we_a[k]),
            .mem_addr          (mem_addr_a[k]),
            .mem_wdata         (mem_wdata_a[k]),
            .mem_rdata         (rpipe[LAT-1]),
            .busy              (busy_a[k]),
            .stat_gnt_cnt      (stat_gnt_a[k]),
            .stat_conflict_cnt (stat_conf_a[k])
        );

        // Single-port memory: read data appears LAT cycles after the address.
        always @(posedge clk) begin
            if (mem_we_a[k]) mem[mem_addr_a[k]] <= mem_wdata_a[k];
            rpipe[0] <= mem[mem_addr_a[k]];
            for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         issue;
        logic [1:0] tag;
        logic [7:0] data;
    } rd_t;

    rd_t        sbq[$];
    logic [7:0] ref_mem [0:65535];
    int         cyc;
    int         n_vec;
    int         n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Check one cycle (inputs already applied), then advance to the next.
    task automatic cyc_check(input logic [1:0] exp_gnt, input logic exp_locked);
        logic [15:0] ea;
        logic        ewe;
        logic [7:0]  ewd;
        int          sel;
        #2;
        sel = exp_gnt[1] ? 1 : 0;
        ea  = (exp_gnt != 2'b00) ? addr[sel]  : 16'h0;
        ewe = (exp_gnt != 2'b00) ? we[sel]    : 1'b0;
        ewd = (exp_gnt != 2'b00) ? wdata[sel] : 8'h0;
        for (int k = 0; k < NI; k++) begin
            logic [1:0] ev;
            logic [7:0] ed;
            logic       inflight;
            ev       = 2'b00;
            ed       = 8'h0;
            inflight = 1'b0;
            foreach (sbq[j]) begin
                if (sbq[j].issue + k + 1 == cyc) begin
                    ev = sbq[j].tag;
                    ed = sbq[j].data;
                end
                if (cyc - sbq[j].issue >= 1 && cyc - sbq[j].issue <= k + 1) inflight = 1'b1;
            end
            check($sformatf("gnt[L%0d]", k + 1), gnt_a[k], exp_gnt);
            check($sformatf("mem_we[L%0d]", k + 1), mem_we_a[k], ewe);
            check($sformatf("mem_addr[L%0d]", k + 1), mem_addr_a[k], ea);
            check($sformatf("mem_wdata[L%0d]", k + 1), mem_wdata_a[k], ewd);
            check($sformatf("rvalid[L%0d]", k + 1), rvalid_a[k], ev);
            if (ev != 2'b00) check($sformatf("rdata[L%0d]", k + 1), rdata_a[k], ed);
            check($sformatf("busy[L%0d]", k + 1), busy_a[k],
                  (exp_gnt != 2'b00) | exp_locked | inflight);
        end
        while (sbq.size() > 0 && sbq[0].issue + NI <= cyc) void'(sbq.pop_front());
        if (exp_gnt != 2'b00) begin
            if (ewe) ref_mem[ea] = ewd;
            else     sbq.push_back('{issue: cyc, tag: exp_gnt, data: ref_mem[ea]});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        req = 2'b00; lock = 2'b00; we = 2'b00;
        repeat (n) cyc_check(2'b00, 1'b0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        rst_n = 1'b0;
        req = 2'b00; lock = 2'b00; we = 2'b00; addr = '0; wdata = '0;

        // Reset, then idle.
        repeat (2) cyc_check(2'b00, 1'b0);
        rst_n = 1'b1;
        idle(10);

        // Preload through the arbiter; a lone requester wins every cycle.
        req = 2'b01; we = 2'b01; addr[0] = 16'h0004; wdata[0] = 8'hA5;
        cyc_check(2'b01, 1'b0);
        addr[0] = 16'h0001; wdata[0] = 8'h3C;
        cyc_check(2'b01, 1'b0);
        req = 2'b10; we = 2'b10; addr[1] = 16'h0002; wdata[1] = 8'hC3;
        cyc_check(2'b10, 1'b0);

        // Round-robin between two writers (pointer wraps 1 -> 0).
        req = 2'b11; we = 2'b11;
        addr[0] = 16'h0010; wdata[0] = 8'h11;
        addr[1] = 16'h0200; wdata[1] = 8'h22;
        cyc_check(2'b01, 1'b0);
        cyc_check(2'b10, 1'b0);
        cyc_check(2'b01, 1'b0);
        cyc_check(2'b10, 1'b0);
        idle(1);

        // Back-to-back reads from both requesters, returned in issue order.
        req = 2'b11; we = 2'b00; addr[0] = 16'h0001; addr[1] = 16'h0002;
        cyc_check(2'b01, 1'b0);
        req = 2'b10;
        cyc_check(2'b10, 1'b0);
        idle(4);

        // Single fetch read.
        req = 2'b01; addr[0] = 16'h0004;
        cyc_check(2'b01, 1'b0);
        idle(4);

        // Exec write burst while fetch waits exactly four cycles.
        req = 2'b11; lock = 2'b10; we = 2'b10; addr[0] = 16'h0010;
        addr[1] = 16'h0300; wdata[1] = 8'hB0;
        cyc_check(2'b10, 1'b0);
        addr[1] = 16'h0301; wdata[1] = 8'hB1;
        cyc_check(2'b10, 1'b1);
        addr[1] = 16'h0302; wdata[1] = 8'hB2;
        cyc_check(2'b10, 1'b1);
        addr[1] = 16'h0303; wdata[1] = 8'hB3; lock = 2'b00;
        cyc_check(2'b10, 1'b1);
        req = 2'b01; we = 2'b00;
        cyc_check(2'b01, 1'b0);

        // Locked read-back of the burst.
        req = 2'b10; lock = 2'b10; we = 2'b00; addr[1] = 16'h0300;
        cyc_check(2'b10, 1'b0);
        addr[1] = 16'h0301;
        cyc_check(2'b10, 1'b1);
        addr[1] = 16'h0302;
        cyc_check(2'b10, 1'b1);
        addr[1] = 16'h0303; lock = 2'b00;
        cyc_check(2'b10, 1'b1);
        idle(4);

        // Owner drops req mid-lock: no grant that cycle, then fetch wins.
        req = 2'b10; lock = 2'b10; we = 2'b10; addr[1] = 16'h0305; wdata[1] = 8'h55;
        cyc_check(2'b10, 1'b0);
        req = 2'b01; we = 2'b01; addr[0] = 16'h0306; wdata[0] = 8'h66;
        cyc_check(2'b00, 1'b1);
        lock = 2'b00;
        cyc_check(2'b01, 1'b0);
        idle(1);

        // Fetch locked read burst, reset with reads in flight.
        req = 2'b01; lock = 2'b01; we = 2'b00; addr[0] = 16'h0300;
        cyc_check(2'b01, 1'b0);
        addr[0] = 16'h0301;
        cyc_check(2'b01, 1'b1);
        rst_n = 1'b0;
        req = 2'b00; lock = 2'b00;
        sbq.delete();
        repeat (2) cyc_check(2'b00, 1'b0);
        rst_n = 1'b1;

        // After reset the pointer is back at requester 0.
        req = 2'b11; we = 2'b00; addr[0] = 16'h0004; addr[1] = 16'h0002;
        cyc_check(2'b01, 1'b0);
        req = 2'b10;
        cyc_check(2'b10, 1'b0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port unified DRAM model (simple_memory) between NUM_REQ requesters: fetch unit, execution-unit load/store engine, and future DMA/debug ports.
- Replaces the state-based address mux in the accelerator top, so fetch and execution may overlap.
- Provides round-robin arbitration, a burst lock so a requester can keep the port, and fixed-latency read-data return tagged per requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 8, memory data width.
- READ_LATENCY, 1, cycles from read issue to valid mem_rdata (1..3).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester access request.
- lock  in  NUM_REQ  hold the grant after the current beat (burst).
- we  in  NUM_REQ  per-requester write enable.
- addr  in  NUM_REQ x ADDR_WIDTH  per-requester address.
- wdata  in  NUM_REQ x DATA_WIDTH  per-requester write data.
- gnt  out  NUM_REQ  one-hot grant; a beat transfers when req[i] and gnt[i] are both high.
- rvalid  out  NUM_REQ  read data valid for requester i.
- rdata  out  DATA_WIDTH  read data, broadcast (mem_rdata passthrough).
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- busy  out  1  a grant is active or reads are in flight.

Behaviour:
- Reset values: gnt=0, rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, rr_ptr=0, state=ST_FREE, tag pipeline cleared.
- gnt is combinational from req, state and rr_ptr; the memory side is muxed combinationally from the granted requester. Issue happens in the grant cycle (zero added latency).
- With no grant, mem_we=0 and mem_addr=mem_wdata=0.
- ST_FREE:
  - Grant the first requesting index at or after rr_ptr, scanning upward with wrap.
  - After the beat, rr_ptr <= winner+1 mod NUM_REQ.
  - If lock[winner] is high in the beat cycle, go to ST_LOCKED with owner=winner.
- ST_LOCKED:
  - gnt=onehot(owner) while req[owner] is high; other requests are ignored.
  - If req[owner] or lock[owner] is low in a cycle, that cycle still grants owner if req[owner] is high.
  - The next state is ST_FREE and rr_ptr <= owner+1.
  - No rr_ptr update occurs while locked.
- mem_we = we[granted] & req[granted].
- Read beats (we=0) push a requester tag into a READ_LATENCY-deep shift pipeline. rvalid[tag] asserts exactly READ_LATENCY cycles after issue, for one cycle per beat. Back-to-back reads from mixed requesters return in issue order.
- Writes produce no rvalid.
- busy = |gnt | (state==ST_LOCKED) | any valid pipeline slot.
- Boundary conditions:
  - All requests low: no grant, rr_ptr unchanged.
  - Single requester: granted every cycle.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - A requester dropping req mid-lock releases the lock in that cycle.
  - Reset mid-burst or with reads in flight discards pending rvalid, releases the lock and returns to ST_FREE.
  - A requester must hold addr/we/wdata stable while req is high and gnt is low.

Optional Feature:
- MEM_ARB_STATS_EN defined: adds per-requester 16-bit saturating grant counters and a 16-bit saturating conflict counter, exposed as outputs stat_gnt_cnt (NUM_REQ x 16) and stat_conflict_cnt (16).
  - A conflict is a cycle with more than one req high.
  - All counters are cleared by reset.
- Not defined: the ports still exist, tied to 0, and no counter flops are inferred.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {ST_FREE, ST_LOCKED}.
  - Requester ID constants REQ_FETCH=0, REQ_EXEC=1.
  - MAX_REQ=4 and the tag width localparam.
- One sub-module, rr_picker: combinational round-robin one-hot select from req and rr_ptr, returning a valid flag and an index.

Test Plan:
- Reset and idle: rst_n low then high, all req=0 → gnt=0, mem_we=0, busy=0, rvalid=0 for 10 cycles.
- Round-robin: req=2'b11 held, no lock → gnt alternates 01,10,01,10. mem_addr alternates fetch addr 0x0010 and exec addr 0x0200.
- Read return: REQ_FETCH reads 0x0004 holding 0xA5, READ_LATENCY=1 → rvalid=01 and rdata=0xA5 one cycle after issue.
  - Repeat with READ_LATENCY=3: response arrives at cycle+3.
- Burst lock: exec asserts req+lock for 4 write beats to 0x0300..0x0303 while fetch requests.
  - Fetch is starved exactly 4 cycles, then granted the cycle after lock drops.
  - Memory holds all 4 bytes.
- Mixed in-flight reads: fetch reads 0x0001 then exec reads 0x0002 back-to-back, READ_LATENCY=2 → rvalid 01 then 10 on consecutive cycles with the correct data.
- Reset mid-burst: assert rst_n low during a locked burst with 2 reads in flight → no rvalid after reset, state ST_FREE, and the first grant goes to requester 0.
